// File: rtl/serial_addsub_param.sv
// serial_addsub_param
//   Digit-serial adder/subtractor. One DIGIT-wide adder slice and a carry flop
//   process two WIDTH-bit operands over WIDTH/DIGIT cycles. Operations are
//   accepted with a valid/ready handshake.
//
//   Ports:
//     clk, reset_n         clock, asynchronous active-low reset
//     in_valid / in_ready  operand handshake; in_ready is high while idle
//     a_in, b_in           operands (two's complement or unsigned)
//     sub, cin             0: A+B+cin, 1: A-B-cin (cin acts as borrow-in)
//     sum_out              result, held until the next completion
//     carry_out            raw carry out of the MSB (sub mode: 1 = no borrow)
//     overflow             signed overflow of the last result
//     done                 one-cycle pulse when the outputs update
//     busy                 operation in progress
//
//   Build option: define SERIAL_ADDSUB_SATURATE_EN to clamp sum_out to the
//   signed limit on overflow. Without it, sum_out wraps modulo 2^WIDTH.
module serial_addsub_param #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             sub,
  input  logic             cin,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow,
  output logic             done,
  output logic             busy
);

  // Parameter legality is checked during elaboration.
  if (WIDTH < 2 || DIGIT == 0 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
    $fatal(1, "serial_addsub_param: WIDTH must be >= 2 and DIGIT must divide WIDTH");
  end

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CntLast = CW'(N - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;

  logic             accept, last;
  logic [DIGIT:0]   slice_full;
  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout, msb_cin, slice_ovf;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0] res_shift, res_final;

  assign accept = in_valid && (state_q == StIdle);
  assign last   = (state_q == StRun) && (cnt_q == CntLast);

  // Adder slice on the low digit of each operand register.
  assign slice_full = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_q};
  assign slice_sum  = slice_full[DIGIT-1:0];
  assign slice_cout = slice_full[DIGIT];
  // Carry into the slice MSB recovered from that bit's sum and operands.
  assign msb_cin    = slice_sum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
  assign slice_ovf  = msb_cin ^ slice_cout;

  // New digit enters at the MSB end; the result register shifts right.
  assign res_cat   = {slice_sum, res_q};
  assign res_shift = res_cat[WIDTH+DIGIT-1:DIGIT];

`ifdef SERIAL_ADDSUB_SATURATE_EN
  // Final carry 0 means positive overflow (0111..1), carry 1 negative (1000..0).
  assign res_final = slice_ovf ? {slice_cout, {(WIDTH-1){~slice_cout}}} : res_shift;
`else
  assign res_final = res_shift;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (last)     state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == StIdle);
    busy     = (state_q == StRun);
  end

  // Datapath next-state
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (accept) begin
      a_d     = a_in;
      b_d     = b_in ^ {WIDTH{sub}};
      carry_d = cin ^ sub;
      cnt_d   = '0;
    end else if (state_q == StRun) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      carry_d = slice_cout;
      res_d   = res_shift;
      cnt_d   = cnt_q + 1'b1;
      if (last) begin
        sum_d  = res_final;
        cout_d = slice_cout;
        ovf_d  = slice_ovf;
        done_d = 1'b1;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign sum_out   = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign done      = done_q;

endmodule
